// File: rtl/tohost_exit_monitor.sv
// ---------------------------------------------------------------------------
// tohost_exit_monitor
//
// Harness-side end of the HTIF-style pass/fail mailbox. Snoops the core's
// 32-bit write bus for writes to the 64-bit tohost word (low word at
// TOHOST_ADDR, high word at TOHOST_ADDR+4). It decodes exit and console
// commands, drives sticky pass/fail flags, and reports the exit code and a
// run-cycle count for post-mortem.
//
// Optional feature: define TOHOST_WATCHDOG_EN to enable a watchdog. The
// watchdog moves the monitor to TIMEOUT after TIMEOUT_CYCLES run cycles
// that contain no exit.
//
// Ports:
//   clock, reset     harness clock (rising edge), synchronous active-high reset
//   io_wr_valid/ready, io_wr_addr/data/strb
//                    write bus; ready is constant 1 once out of reset
//   io_success       sticky pass (PASS state only)
//   io_fail          sticky fail (FAIL or TIMEOUT)
//   io_exit_code     decoded exit code (all ones on timeout)
//   io_timeout       sticky watchdog expiry (tied 0 without the watchdog)
//   io_putc_valid    one-cycle console character strobe
//   io_putc_data     console character
//   io_cycles        saturating RUN-state cycle count, frozen once terminal
// ---------------------------------------------------------------------------
module tohost_exit_monitor #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h8000_1000,
    parameter int          CNT_W          = 32,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_wr_valid,
    output logic             io_wr_ready,
    input  logic [31:0]      io_wr_addr,
    input  logic [31:0]      io_wr_data,
    input  logic [3:0]       io_wr_strb,
    output logic             io_success,
    output logic             io_fail,
    output logic [30:0]      io_exit_code,
    output logic             io_timeout,
    output logic             io_putc_valid,
    output logic [7:0]       io_putc_data,
    output logic [CNT_W-1:0] io_cycles
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [31:0]      TOHOST_HI = TOHOST_ADDR + 32'd4;
    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef TOHOST_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    state_t           state_reg, state_next;
    logic             ready_reg;
    logic [31:0]      lo_word_reg, lo_word_next;
    logic [30:0]      exit_code_reg, exit_code_next;
    logic             putc_valid_reg, putc_valid_next;
    logic [7:0]       putc_data_reg, putc_data_next;
    logic [CNT_W-1:0] cycles_reg, cycles_next;

    logic        wr_fire;
    logic        lo_hit;
    logic        hi_hit;
    logic [31:0] lo_merged;
    logic [31:0] hi_merged;
    logic        is_exit;
    logic        is_putc;
    logic        wd_expire;

    assign wr_fire = io_wr_valid && ready_reg;
    assign lo_hit  = wr_fire && (io_wr_addr == TOHOST_ADDR);
    assign hi_hit  = wr_fire && (io_wr_addr == TOHOST_HI);

    // Low word merges into the held value; the high word has no backing
    // register, so unwritten bytes of it read as zero.
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign lo_merged[8*gi +: 8] = io_wr_strb[gi] ? io_wr_data[8*gi +: 8]
                                                     : lo_word_reg[8*gi +: 8];
        assign hi_merged[8*gi +: 8] = io_wr_strb[gi] ? io_wr_data[8*gi +: 8]
                                                     : 8'h00;
    end

    // device = hi[31:24], cmd = hi[23:16]; lo_word supplies the payload.
    assign is_exit = hi_hit && (hi_merged[31:24] == 8'd0) && lo_word_reg[0];
    assign is_putc = hi_hit && (hi_merged[31:24] == 8'd1)
                            && (hi_merged[23:16] == 8'd1);

    // The expiry condition is evaluated only in RUN; an exit in the same
    // cycle takes priority in the next-state logic below.
    assign wd_expire = WD_EN && (state_reg == ST_RUN) && (cycles_reg == WD_LAST);

    always_comb begin
        state_next      = state_reg;
        lo_word_next    = lo_word_reg;
        exit_code_next  = exit_code_reg;
        putc_valid_next = 1'b0;
        putc_data_next  = putc_data_reg;
        cycles_next     = cycles_reg;

        if (hi_hit) begin
            lo_word_next = '0;
        end else if (lo_hit) begin
            lo_word_next = lo_merged;
        end

        if (state_reg == ST_RUN) begin
            if (cycles_reg != {CNT_W{1'b1}}) begin
                cycles_next = cycles_reg + 1'b1;
            end
            if (is_exit) begin
                exit_code_next = lo_word_reg[31:1];
                state_next     = (lo_word_reg[31:1] == 31'd0) ? ST_PASS : ST_FAIL;
            end else if (wd_expire) begin
                exit_code_next = 31'h7FFF_FFFF;
                state_next     = ST_TIMEOUT;
            end
            if (is_putc) begin
                putc_valid_next = 1'b1;
                putc_data_next  = lo_word_reg[7:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_RUN;
            ready_reg      <= 1'b0;
            lo_word_reg    <= '0;
            exit_code_reg  <= '0;
            putc_valid_reg <= 1'b0;
            putc_data_reg  <= '0;
            cycles_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            ready_reg      <= 1'b1;
            lo_word_reg    <= lo_word_next;
            exit_code_reg  <= exit_code_next;
            putc_valid_reg <= putc_valid_next;
            putc_data_reg  <= putc_data_next;
            cycles_reg     <= cycles_next;
        end
    end

    assign io_wr_ready   = ready_reg;
    assign io_success    = (state_reg == ST_PASS);
    assign io_fail       = (state_reg == ST_FAIL) || (state_reg == ST_TIMEOUT);
`ifdef TOHOST_WATCHDOG_EN
    assign io_timeout    = (state_reg == ST_TIMEOUT);
`else
    assign io_timeout    = 1'b0;
`endif
    assign io_exit_code  = exit_code_reg;
    assign io_putc_valid = putc_valid_reg;
    assign io_putc_data  = putc_data_reg;
    assign io_cycles     = cycles_reg;

endmodule

// File: tb/tb_tohost_exit_monitor.sv
// ---------------------------------------------------------------------------
// tb_tohost_exit_monitor
//
// Directed testbench for tohost_exit_monitor. It checks exit pass/fail,
// console, partial writes, ignored writes, terminal behaviour, reset
// recovery and the watchdog (or its absence).
// ---------------------------------------------------------------------------
module tb_tohost_exit_monitor;

    localparam logic [31:0] TA = 32'h8000_1000;
    localparam int          CW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          io_wr_valid;
    logic          io_wr_ready;
    logic [31:0]   io_wr_addr;
    logic [31:0]   io_wr_data;
    logic [3:0]    io_wr_strb;
    logic          io_success;
    logic          io_fail;
    logic [30:0]   io_exit_code;
    logic          io_timeout;
    logic          io_putc_valid;
    logic [7:0]    io_putc_data;
    logic [CW-1:0] io_cycles;

    int checks   = 0;
    int failures = 0;

    tohost_exit_monitor #(
        .TOHOST_ADDR    (TA),
        .CNT_W          (CW),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_wr_valid   (io_wr_valid),
        .io_wr_ready   (io_wr_ready),
        .io_wr_addr    (io_wr_addr),
        .io_wr_data    (io_wr_data),
        .io_wr_strb    (io_wr_strb),
        .io_success    (io_success),
        .io_fail       (io_fail),
        .io_exit_code  (io_exit_code),
        .io_timeout    (io_timeout),
        .io_putc_valid (io_putc_valid),
        .io_putc_data  (io_putc_data),
        .io_cycles     (io_cycles)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Presents one write for a single clock; returns 1 ns after the edge
    // that accepted it, so registered results are already visible.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        io_wr_valid = 1'b1;
        io_wr_addr  = addr;
        io_wr_data  = data;
        io_wr_strb  = strb;
        @(posedge clock);
        #1;
        io_wr_valid = 1'b0;
        io_wr_addr  = '0;
        io_wr_data  = '0;
        io_wr_strb  = '0;
    endtask

    // Reset for n cycles, then one free-running edge so ready is high and
    // io_cycles reads 1 on return.
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        io_wr_valid = 1'b0;
        io_wr_addr  = '0;
        io_wr_data  = '0;
        io_wr_strb  = '0;

        // Reset state, then exit 0.
        repeat (20) @(posedge clock);
        #1;
        check("rst_ready",   32'(io_wr_ready), 32'd0);
        check("rst_success", 32'(io_success),  32'd0);
        check("rst_fail",    32'(io_fail),     32'd0);
        check("rst_cycles",  io_cycles,        32'd0);
        reset = 1'b0;
        idle(1);
        check("ready_up",    32'(io_wr_ready), 32'd1);
        check("cycles_1",    io_cycles,        32'd1);
        do_write(TA, 32'h1, 4'hF);
        check("lo_no_effect", 32'(io_success), 32'd0);
        do_write(TA + 4, 32'h0, 4'hF);
        check("pass_success", 32'(io_success),  32'd1);
        check("pass_fail",    32'(io_fail),     32'd0);
        check("pass_code",    32'(io_exit_code), 32'd0);
        check("pass_cycles",  io_cycles,        32'd3);
        idle(5);
        check("pass_frozen",  io_cycles,        32'd3);
        // Terminal: console command ignored.
        do_write(TA, 32'h41, 4'hF);
        do_write(TA + 4, 32'h0101_0000, 4'hF);
        check("term_no_putc", 32'(io_putc_valid), 32'd0);
        // Mid-operation reset from PASS.
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_success", 32'(io_success),  32'd0);
        check("mid_rst_ready",   32'(io_wr_ready), 32'd0);
        check("mid_rst_cycles",  io_cycles,        32'd0);
        reset = 1'b0;
        idle(1);
        check("mid_rst_ready_up", 32'(io_wr_ready), 32'd1);
        check("mid_rst_cycles_1", io_cycles,        32'd1);

        // Exit code 3 -> FAIL, then a later exit 0 leaves it untouched.
        do_write(TA, 32'h7, 4'hF);
        do_write(TA + 4, 32'h0, 4'hF);
        check("fail_flag",    32'(io_fail),      32'd1);
        check("fail_code",    32'(io_exit_code), 32'd3);
        check("fail_success", 32'(io_success),   32'd0);
        do_write(TA, 32'h1, 4'hF);
        do_write(TA + 4, 32'h0, 4'hF);
        check("fail_sticky",  32'(io_fail),      32'd1);
        check("fail_no_pass", 32'(io_success),   32'd0);
        check("fail_code_kept", 32'(io_exit_code), 32'd3);

        // Console character, then a bare hi write sees the cleared lo word.
        do_reset(1);
        do_write(TA, 32'h41, 4'hF);
        do_write(TA + 4, 32'h0101_0000, 4'hF);
        check("putc_valid",   32'(io_putc_valid), 32'd1);
        check("putc_data",    32'(io_putc_data),  32'h41);
        check("putc_run",     32'({io_success, io_fail}), 32'd0);
        idle(1);
        check("putc_pulse_end", 32'(io_putc_valid), 32'd0);
        do_write(TA + 4, 32'h0, 4'hF);
        check("hi_alone_pass", 32'(io_success), 32'd0);
        check("hi_alone_fail", 32'(io_fail),    32'd0);

        // Writes to TOHOST_ADDR+8 are accepted and ignored.
        do_write(TA + 8, 32'h1, 4'hF);
        do_write(TA + 4, 32'h0, 4'hF);
        check("addr8_ignored", 32'({io_success, io_fail}), 32'd0);
        check("addr8_ready",   32'(io_wr_ready), 32'd1);

        // Partial lo write: only byte 0 lands, junk upper bytes masked.
        do_write(TA, 32'hFFFF_FF01, 4'b0001);
        do_write(TA + 4, 32'h0, 4'hF);
        check("partial_lo_pass", 32'(io_success), 32'd1);
        check("partial_lo_code", 32'(io_exit_code), 32'd0);

        // Partial hi write: device/cmd bytes unwritten read as 0 -> exit with
        // code 0x41>>1 = 0x20.
        do_reset(1);
        do_write(TA, 32'h41, 4'hF);
        do_write(TA + 4, 32'h0101_0000, 4'b0011);
        check("partial_hi_putc", 32'(io_putc_valid), 32'd0);
        check("partial_hi_fail", 32'(io_fail),       32'd1);
        check("partial_hi_code", 32'(io_exit_code),  32'h20);

`ifdef TOHOST_WATCHDOG_EN
        // Idle run: TIMEOUT after 100 RUN cycles.
        do_reset(1);
        idle(120);
        check("wd_timeout", 32'(io_timeout),   32'd1);
        check("wd_fail",    32'(io_fail),      32'd1);
        check("wd_success", 32'(io_success),   32'd0);
        check("wd_code",    32'(io_exit_code), 32'h7FFF_FFFF);
        check("wd_cycles",  io_cycles,         32'd100);
        // Exit 0 on the expiry cycle wins.
        do_reset(1);
        do_write(TA, 32'h1, 4'hF);
        idle(97);
        check("wd_pre_cycles", io_cycles, 32'd99);
        do_write(TA + 4, 32'h0, 4'hF);
        check("wd_race_pass",    32'(io_success), 32'd1);
        check("wd_race_timeout", 32'(io_timeout), 32'd0);
        check("wd_race_cycles",  io_cycles,       32'd100);
`else
        // No watchdog: idle well past 100 cycles stays in RUN.
        do_reset(1);
        idle(150);
        check("nowd_timeout", 32'(io_timeout), 32'd0);
        check("nowd_fail",    32'(io_fail),    32'd0);
        check("nowd_cycles",  io_cycles,       32'd151);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tohost_exit_monitor.md
Name: tohost_exit_monitor

Overview:
- Harness-side end of the simulation pass/fail interface: snoops the core's 32-bit write bus for writes to the 64-bit HTIF-style tohost mailbox, decodes exit and console commands, and drives the sticky io_success flag sampled by the top-level bench.
- Sits inside TestHarness between the memory-mapped write path and the harness outputs.
- Also reports fail/exit code and a run-cycle count for post-mortem.

Parameters:
- TOHOST_ADDR, 32'h8000_1000, byte address of tohost low word; high word at TOHOST_ADDR+4; must be 8-byte aligned.
- CNT_W, 32, width of run-cycle counter.
- TIMEOUT_CYCLES, 1000000, watchdog limit in RUN cycles (used only with the watchdog feature).

Ports:
- clock  in  1  harness clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- io_wr_valid  in  1  write request valid.
- io_wr_ready  out  1  write accept.
- io_wr_addr  in  32  byte address, word aligned.
- io_wr_data  in  32  write data.
- io_wr_strb  in  4  byte enables.
- io_success  out  1  sticky pass.
- io_fail  out  1  sticky fail (nonzero exit code or timeout).
- io_exit_code  out  31  decoded exit code.
- io_timeout  out  1  sticky watchdog expiry.
- io_putc_valid  out  1  one-cycle console character pulse.
- io_putc_data  out  8  console character.
- io_cycles  out  CNT_W  RUN-state cycle count.

Behaviour:
- Reset (synchronous, active-high; clock/reset named as in TestHarness): state=RUN, all outputs 0, lo_word=0, io_wr_ready=0 during the reset cycle and 1 from the first cycle after reset deasserts. Reset mid-operation returns everything to reset values, including terminal states.
- Handshake: a write is accepted when io_wr_valid && io_wr_ready. Ready is a registered constant 1 out of reset, with no backpressure. Non-tohost addresses are accepted and ignored.
- Low-word write (addr==TOHOST_ADDR): byte-merge into lo_word per io_wr_strb; no other effect.
- High-word write (addr==TOHOST_ADDR+4): forms cmd64 = {merged hi, lo_word}; decode in the same cycle; lo_word clears to 0 on the next edge.
  - device = hi[31:24], cmd = hi[23:16].
  - device 0, lo[0]=1: exit. code = lo[31:1]. code==0 -> PASS; else -> FAIL, io_exit_code=code.
  - device 1, cmd 1: console. io_putc_valid=1 for exactly one cycle, io_putc_data=lo[7:0].
  - Anything else, including device 0 with lo[0]=0: ignored.
  - A high write with no prior low write uses lo_word=0, so it is ignored.
- Latency: outputs update on the edge after the high-word handshake, i.e. visible 1 cycle after acceptance.
- States: RUN -> PASS (exit 0); RUN -> FAIL (exit !=0); RUN -> TIMEOUT (watchdog only). PASS, FAIL and TIMEOUT are terminal until reset.
- Terminal behaviour: writes are still accepted; commands are ignored (no putc, no flag change).
- Flag encoding: io_success=1 only in PASS. io_fail=1 in FAIL or TIMEOUT. io_success and io_fail are never both 1.
- io_cycles increments every RUN cycle, saturates at all-ones, and freezes on entering a terminal state.
- Simultaneous events: an exit handshake in the same cycle the watchdog expires -> exit wins.

Optional Feature:
- Macro: TOHOST_WATCHDOG_EN.
- Defined: when io_cycles reaches TIMEOUT_CYCLES-1 in RUN with no exit that cycle, move to TIMEOUT on the next edge. io_timeout=1, io_fail=1, io_exit_code=31'h7FFF_FFFF.
- Undefined: no TIMEOUT state; io_timeout tied 0; the module runs until an exit write.

Test Plan:
- Reset 20 cycles, release, write lo=32'h1 then hi=32'h0 at TOHOST_ADDR/+4 -> io_success=1 one cycle after the hi handshake, io_fail=0, io_exit_code=0, io_cycles frozen.
- Write lo=32'h7 (code 3), hi=0 -> io_fail=1, io_exit_code=3, io_success=0. A later exit-0 write leaves the flags unchanged.
- Write lo=32'h41, hi=32'h0101_0000 -> single-cycle io_putc_valid with io_putc_data=8'h41; state stays RUN.
- Partial writes: lo strb=4'b0001 data=8'h01, then hi=0 -> PASS. Hi alone without lo -> ignored. Writes to TOHOST_ADDR+8 -> accepted, no effect.
- Reach PASS, then assert reset for 1 cycle -> all outputs 0, ready low that cycle then high, io_cycles restarts from 0.
- With TOHOST_WATCHDOG_EN and TIMEOUT_CYCLES=100, issue no writes -> io_timeout=io_fail=1 after 100 RUN cycles. Repeat with an exit-0 handshake on the expiry cycle -> PASS, io_timeout=0.
